adc_sample_buffer: RTL and testbench

- Upstream stage of main_waveform; owns the ADC controller handshake (go/done/data).
- Requests conversions at a fixed sample rate and writes samples into a ping-pong buffer of DEPTH entries, one entry per display column.
- The display side reads the stable bank by column address.
- Banks swap only on a frame-swap pulse, so the trace never tears mid-frame.

---
 rtl/waveform_pkg.sv | 20 ++
 rtl/adc_sample_buffer_if.sv | 17 +
 rtl/sample_dpram.sv | 29 ++
 rtl/adc_sample_buffer.sv | 152 +++++++++++++++
 tb/tb_adc_sample_buffer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/waveform_pkg.sv
// Shared types and default sizing for the waveform capture path.
package waveform_pkg;

   localparam int ADC_W      = 12;
   localparam int DEPTH      = 640;
   localparam int ADDR_W     = $clog2(DEPTH);
   localparam int SAMPLE_DIV = 1024;
   localparam int TIMEOUT    = 64;

   typedef logic [ADC_W-1:0] sample_t;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      STORE,
      FULL
   } cap_state_t;

endpackage

// File: rtl/adc_sample_buffer_if.sv
// ADC controller handshake bundle.
//
// Handshake: the requester raises go and holds it high until it sees done
// (or gives up). done is a single-cycle strobe from the controller and data
// is only meaningful in the cycle done is high. done while go is low means
// nothing and is ignored by the requester.
interface adc_sample_buffer_if;
   import waveform_pkg::*;

   logic    go;
   logic    done;
   sample_t data;

   modport master (output go, input done, input data);
   modport slave  (input go, output done, output data);

endinterface

// File: rtl/sample_dpram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// Contents are not reset.
module sample_dpram #(
   parameter int AW = 11
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [AW-1:0]        waddr,
   input  waveform_pkg::sample_t wdata,
   input  logic [AW-1:0]        raddr,
   output waveform_pkg::sample_t rdata
);
   import waveform_pkg::*;

   sample_t mem [2**AW];

   // Write port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Registered read port, one cycle of latency.
   always_ff @(posedge clk) begin
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/adc_sample_buffer.sv
// Paces ADC conversions and fills a ping-pong sample buffer for the
// waveform display. The capture bank is wr_bank, the display bank is its
// complement; banks only swap on a frame-swap pulse once a capture is full.
module adc_sample_buffer #(
   parameter int DEPTH      = waveform_pkg::DEPTH,
   parameter int SAMPLE_DIV = waveform_pkg::SAMPLE_DIV,
   parameter int TIMEOUT    = waveform_pkg::TIMEOUT,
   localparam int ADDR_W    = $clog2(DEPTH)
) (
   input  logic                     clk_50_i,
   input  logic                     rst_i,
   adc_sample_buffer_if.master      adc,
   input  logic                     frame_swap_i,
   input  logic [ADDR_W-1:0]        rd_addr_i,
   output waveform_pkg::sample_t    rd_data_o,
   output logic                     buf_ready_o,
   output logic                     timeout_err_o,
   output waveform_pkg::cap_state_t state_o,
   output logic [ADDR_W-1:0]        wr_ptr_o,
   output logic                     wr_bank_o
);
   import waveform_pkg::*;

   localparam int DIV_W = $clog2(SAMPLE_DIV);
   localparam int TO_W  = $clog2(TIMEOUT);
   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

   cap_state_t        state_q, state_d;
   logic [DIV_W-1:0]  div_q;
   logic              tick;
   logic [TO_W-1:0]   tcnt_q, tcnt_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              bank_q, bank_d;
   logic              ready_q, ready_d;
   logic              err_q, err_d;
   logic              go_q;
   logic              ram_we;
   logic              addr_ok_q;
   sample_t           ram_rdata;

   assign tick = (div_q == DIV_W'(SAMPLE_DIV - 1));

   // Free-running sample-rate divider; ticks are simply lost if the FSM is busy.
   always_ff @(posedge clk_50_i) begin
      if (rst_i || tick) begin
         div_q <= '0;
      end else begin
         div_q <= div_q + DIV_W'(1);
      end
   end

   // Capture FSM next-state and datapath updates.
   always_comb begin
      state_d = state_q;
      tcnt_d  = tcnt_q;
      ptr_d   = ptr_q;
      bank_d  = bank_q;
      ready_d = ready_q;
      err_d   = err_q;
      ram_we  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (tick) begin
               state_d = REQ;
            end
         end
         REQ: begin
            tcnt_d  = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // A done in the last allowed cycle still counts as a sample.
            if (adc.done) begin
               ram_we  = 1'b1;
               state_d = STORE;
            end else if (tcnt_q == TO_W'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               tcnt_d = tcnt_q + TO_W'(1);
            end
         end
         STORE: begin
            if (ptr_q == ADDR_W'(DEPTH - 1)) begin
               state_d = FULL;
            end else begin
               ptr_d   = ptr_q + ADDR_W'(1);
               state_d = IDLE;
            end
         end
         FULL: begin
            if (frame_swap_i) begin
               bank_d  = ~bank_q;
               ptr_d   = '0;
               ready_d = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Capture FSM state and registered outputs; go is high exactly while in WAIT.
   always_ff @(posedge clk_50_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         tcnt_q  <= '0;
         ptr_q   <= '0;
         bank_q  <= 1'b0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         go_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
         ptr_q   <= ptr_d;
         bank_q  <= bank_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         go_q    <= (state_d == WAIT);
      end
   end

   // Remember whether the read address was in range so the output can be zeroed.
   always_ff @(posedge clk_50_i) begin
      if (rst_i) begin
         addr_ok_q <= 1'b0;
      end else begin
         addr_ok_q <= ({1'b0, rd_addr_i} < DEPTH_W);
      end
   end

   // Bank is the address MSB; the read side samples the pre-swap bank on a
   // swap cycle because bank_q only changes at that same edge.
   sample_dpram #(.AW(ADDR_W + 1)) u_ram (
      .clk   (clk_50_i),
      .we    (ram_we),
      .waddr ({bank_q, ptr_q}),
      .wdata (adc.data),
      .raddr ({~bank_q, rd_addr_i}),
      .rdata (ram_rdata)
   );

   assign adc.go        = go_q;
   assign rd_data_o     = addr_ok_q ? ram_rdata : '0;
   assign buf_ready_o   = ready_q;
   assign timeout_err_o = err_q;
   assign state_o       = state_q;
   assign wr_ptr_o      = ptr_q;
   assign wr_bank_o     = bank_q;

endmodule

// File: tb/tb_adc_sample_buffer.sv
// Directed bench for adc_sample_buffer with DEPTH=16, SAMPLE_DIV=8, TIMEOUT=64.
module tb_adc_sample_buffer;
   import waveform_pkg::*;

   localparam int T_DEPTH = 16;
   localparam int T_DIV   = 8;
   localparam int T_TO    = 64;

   logic       clk = 1'b0;
   logic       rst;
   logic       frame_swap;
   logic [3:0] rd_addr;
   sample_t    rd_data;
   logic       buf_ready;
   logic       timeout_err;
   cap_state_t st;
   logic [3:0] wr_ptr;
   logic       wr_bank;

   logic       model_done = 1'b0;
   sample_t    model_data = '0;
   logic       man_done   = 1'b0;
   sample_t    man_data   = '0;
   logic       adc_en     = 1'b0;
   logic       go_prev    = 1'b0;
   int         go_age     = 0;
   int         go_pulses  = 0;
   int         next_val   = 0;

   int         n_cmp  = 0;
   int         n_fail = 0;

   adc_sample_buffer_if bus ();

   assign bus.done = model_done | man_done;
   assign bus.data = man_done ? man_data : model_data;

   adc_sample_buffer #(
      .DEPTH      (T_DEPTH),
      .SAMPLE_DIV (T_DIV),
      .TIMEOUT    (T_TO)
   ) dut (
      .clk_50_i      (clk),
      .rst_i         (rst),
      .adc           (bus.master),
      .frame_swap_i  (frame_swap),
      .rd_addr_i     (rd_addr),
      .rd_data_o     (rd_data),
      .buf_ready_o   (buf_ready),
      .timeout_err_o (timeout_err),
      .state_o       (st),
      .wr_ptr_o      (wr_ptr),
      .wr_bank_o     (wr_bank)
   );

   // Clock.
   always #5 clk = ~clk;

   // ADC controller model: done two cycles after go, data = previous + 1.
   always @(negedge clk) begin
      model_done = 1'b0;
      if (bus.go && !go_prev) go_pulses++;
      go_prev = bus.go;
      if (adc_en && bus.go) begin
         go_age++;
         if (go_age == 2) begin
            next_val++;
            model_done = 1'b1;
            model_data = sample_t'(next_val);
         end
      end else begin
         go_age = 0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic wait_state(input cap_state_t s, input int budget, input string tag);
      int n = 0;
      while (st !== s && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(st === s), 32'd1);
   endtask

   task automatic wait_go(input int budget, input string tag);
      int n = 0;
      while (bus.go !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(bus.go === 1'b1), 32'd1);
   endtask

   task automatic swap_pulse();
      frame_swap = 1'b1;
      @(negedge clk);
      frame_swap = 1'b0;
   endtask

   initial begin
      int n;
      int exp_first;

      // Reset.
      rst        = 1'b1;
      frame_swap = 1'b0;
      rd_addr    = '0;
      repeat (3) @(negedge clk);
      chk("rst_go",      32'(bus.go),      32'd0);
      chk("rst_ready",   32'(buf_ready),   32'd0);
      chk("rst_err",     32'(timeout_err), 32'd0);
      chk("rst_rd_data", 32'(rd_data),     32'd0);
      chk("rst_state",   32'(st),          32'(IDLE));
      chk("rst_ptr",     32'(wr_ptr),      32'd0);
      chk("rst_bank",    32'(wr_bank),     32'd0);
      rst = 1'b0;

      // Spurious done in IDLE.
      @(negedge clk);
      man_done = 1'b1;
      man_data = 12'hABC;
      @(negedge clk);
      man_done = 1'b0;
      chk("spur_state", 32'(st),     32'(IDLE));
      chk("spur_ptr",   32'(wr_ptr), 32'd0);

      // First capture, with an early swap pulse that must be ignored.
      go_pulses = 0;
      adc_en    = 1'b1;
      n = 0;
      while (wr_ptr !== 4'd5 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("reach_ptr5", 32'(wr_ptr === 4'd5), 32'd1);
      swap_pulse();
      chk("early_swap_ready", 32'(buf_ready), 32'd0);
      chk("early_swap_bank",  32'(wr_bank),   32'd0);
      wait_state(FULL, 400, "cap1_full");
      chk("cap1_go_pulses", 32'(go_pulses), 32'd16);
      chk("cap1_ptr",       32'(wr_ptr),    32'd15);
      chk("cap1_ready",     32'(buf_ready), 32'd0);
      repeat (30) @(negedge clk);
      chk("full_no_go",     32'(go_pulses), 32'd16);
      chk("full_go_low",    32'(bus.go),    32'd0);
      chk("full_hold",      32'(st),        32'(FULL));

      // Swap and read the first capture.
      swap_pulse();
      chk("swap1_ready", 32'(buf_ready), 32'd1);
      chk("swap1_bank",  32'(wr_bank),   32'd1);
      chk("swap1_ptr",   32'(wr_ptr),    32'd0);
      chk("swap1_state", 32'(st),        32'(IDLE));
      for (int a = 0; a < T_DEPTH; a++) begin
         rd_addr = 4'(a);
         @(negedge clk);
         chk($sformatf("rd_cap1_%0d", a), 32'(rd_data), 32'(a + 1));
      end

      // Second capture; swap and read on the same cycle.
      wait_state(FULL, 400, "cap2_full");
      chk("cap2_ready_kept", 32'(buf_ready), 32'd1);
      rd_addr = 4'd3;
      swap_pulse();
      chk("swap_read_old", 32'(rd_data), 32'd4);
      @(negedge clk);
      chk("swap_read_new", 32'(rd_data), 32'd20);
      for (int a = 0; a < T_DEPTH; a++) begin
         rd_addr = 4'(a);
         @(negedge clk);
         chk($sformatf("rd_cap2_%0d", a), 32'(rd_data), 32'(a + 17));
      end

      // Reset while waiting for a conversion.
      wait_state(WAIT, 40, "cap3_wait");
      rst = 1'b1;
      @(negedge clk);
      chk("rstw_go",    32'(bus.go),      32'd0);
      chk("rstw_state", 32'(st),          32'(IDLE));
      chk("rstw_ready", 32'(buf_ready),   32'd0);
      chk("rstw_ptr",   32'(wr_ptr),      32'd0);
      chk("rstw_err",   32'(timeout_err), 32'd0);
      rst    = 1'b0;
      adc_en = 1'b0;
      @(negedge clk);
      man_done = 1'b1;
      man_data = 12'h5A5;
      @(negedge clk);
      man_done = 1'b0;
      chk("late_done_state", 32'(st),     32'(IDLE));
      chk("late_done_ptr",   32'(wr_ptr), 32'd0);

      // Timeout: no done at all.
      wait_go(20, "to_go_rise");
      n = 0;
      while (bus.go === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
      chk("to_go_cycles", 32'(n),           32'd64);
      chk("to_err",       32'(timeout_err), 32'd1);
      chk("to_ptr",       32'(wr_ptr),      32'd0);
      chk("to_state",     32'(st),          32'(IDLE));
      wait_go(20, "to_next_go");

      // Post-reset capture: first sample must land at address 0.
      exp_first = next_val + 1;
      adc_en    = 1'b1;
      wait_state(FULL, 400, "cap4_full");
      chk("cap4_ready_before", 32'(buf_ready),   32'd0);
      chk("cap4_err_sticky",   32'(timeout_err), 32'd1);
      swap_pulse();
      chk("cap4_ready_after",  32'(buf_ready),   32'd1);
      rd_addr = 4'd0;
      @(negedge clk);
      chk("cap4_rd0",  32'(rd_data), 32'(exp_first));
      rd_addr = 4'd15;
      @(negedge clk);
      chk("cap4_rd15", 32'(rd_data), 32'(exp_first + 15));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
